// File: rtl/single_bus_interconnect.sv
// Single-bus interconnect: address decode, per-slave wait states that drive
// the core stall, read-data multiplexing and unmapped-access error capture.
module single_bus_interconnect #(
    parameter int ADDR_BUS_WIDTH = 16,
    parameter int NR_OF_SLAVES = 4,
    parameter logic [ADDR_BUS_WIDTH*NR_OF_SLAVES-1:0] SLAVE_BASE =
        {16'h1000, 16'h2000, 16'h4000, 16'h8000},
    parameter logic [ADDR_BUS_WIDTH*NR_OF_SLAVES-1:0] SLAVE_MASK =
        {16'hF000, 16'hE000, 16'hC000, 16'h8000},
    parameter logic [4*NR_OF_SLAVES-1:0] SLAVE_WAIT = 16'h2010,
    parameter string SYNCHRONOUS_OUTPUT = "TRUE"
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_req,
    input  logic [ADDR_BUS_WIDTH-1:0]  m_addr,
    input  logic [31:0]                m_out,
    input  logic                       m_write_w,
    input  logic                       m_write_h,
    input  logic                       m_write_b,
    output logic [31:0]                m_in,
    output logic                       m_stall,
    output logic [NR_OF_SLAVES-1:0]    s_cs,
    output logic [ADDR_BUS_WIDTH-1:0]  s_addr,
    output logic [31:0]                s_in,
    output logic                       s_write_w,
    output logic                       s_write_h,
    output logic                       s_write_b,
    input  logic [32*NR_OF_SLAVES-1:0] s_dat,
    output logic                       bus_err,
    output logic [ADDR_BUS_WIDTH-1:0]  err_addr,
    output logic [7:0]                 err_cnt
);

    localparam int IDX_W = (NR_OF_SLAVES > 1) ? $clog2(NR_OF_SLAVES) : 1;
    // Registered slave outputs cost every slave one extra cycle.
    localparam logic [4:0] SYNC_LAT = (SYNCHRONOUS_OUTPUT == "TRUE") ? 5'd1 : 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic [4:0]                cnt_reg;
    logic [31:0]               m_in_reg;
    logic [ADDR_BUS_WIDTH-1:0] err_latch_reg;
    logic [ADDR_BUS_WIDTH-1:0] err_addr_reg;
    logic [7:0]                err_cnt_reg;

    logic [NR_OF_SLAVES-1:0]   hit;
    logic [4:0]                slave_lat [NR_OF_SLAVES];
    logic                      hit_any;
    logic [IDX_W-1:0]          hit_idx;
    logic [4:0]                lat_hit;
    logic [IDX_W-1:0]          sel_idx;
    logic [31:0]               rd_data;
    logic                      complete;
    logic                      is_write;

    // Per-slave window match and total access latency.
    generate
        for (genvar gi = 0; gi < NR_OF_SLAVES; gi++) begin : g_slave
            assign hit[gi] = ((m_addr & SLAVE_MASK[gi*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH])
                              == SLAVE_BASE[gi*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH]);
            assign slave_lat[gi] = {1'b0, SLAVE_WAIT[gi*4 +: 4]} + SYNC_LAT;
        end
    endgenerate

    // Priority encode the hits: the lowest index wins on overlapping windows.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NR_OF_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign lat_hit  = slave_lat[hit_idx];
    assign sel_idx  = (state_reg == ST_WAIT) ? idx_reg : hit_idx;
    assign rd_data  = s_dat[sel_idx*32 +: 32];
    assign is_write = m_write_w | m_write_h | m_write_b;

    assign s_addr   = m_addr;
    assign s_in     = m_out;
    assign bus_err  = (state_reg == ST_ERR);
    assign err_addr = err_addr_reg;
    assign err_cnt  = err_cnt_reg;

    // Bus-side outputs: selects, stall, gated strobes and read-data mux.
    // Everything is forced idle while reset is held so the reset is visible at once.
    always_comb begin
        s_cs      = '0;
        m_stall   = 1'b0;
        complete  = 1'b0;
        m_in      = m_in_reg;
        s_write_w = 1'b0;
        s_write_h = 1'b0;
        s_write_b = 1'b0;
        if (!rst && m_req) begin
            case (state_reg)
                ST_IDLE: begin
                    if (hit_any) begin
                        s_cs[hit_idx] = 1'b1;
                        if (lat_hit == 5'd0) begin
                            complete = 1'b1;
                        end else begin
                            m_stall = 1'b1;
                        end
                    end else begin
                        m_stall = 1'b1;
                        m_in    = 32'h0;
                    end
                end
                ST_WAIT: begin
                    s_cs[idx_reg] = 1'b1;
                    if (cnt_reg == 5'd0) begin
                        complete = 1'b1;
                    end else begin
                        m_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Strobes only pass in the completion cycle, so each write lands once.
        if (complete) begin
            m_in      = rd_data;
            s_write_w = m_write_w;
            s_write_h = m_write_h;
            s_write_b = m_write_b;
        end
    end

    // Access FSM, wait counter, read-data hold and error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            m_in_reg      <= '0;
            err_latch_reg <= '0;
            err_addr_reg  <= '0;
            err_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (m_req) begin
                        if (hit_any) begin
                            if (lat_hit != 5'd0) begin
                                idx_reg   <= hit_idx;
                                cnt_reg   <= lat_hit - 5'd1;
                                state_reg <= ST_WAIT;
                            end
                        end else begin
                            err_latch_reg <= m_addr;
                            state_reg     <= ST_ERR;
                        end
                    end
                end
                ST_WAIT: begin
                    // A dropped request aborts; otherwise count down to completion.
                    if (!m_req || cnt_reg == 5'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                ST_ERR: begin
                    err_addr_reg <= err_latch_reg;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (complete && !is_write) begin
                m_in_reg <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_single_bus_interconnect.sv
// Directed bench for single_bus_interconnect: default map plus an overlapping map.
module tb_single_bus_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req;
    logic [15:0]  m_addr;
    logic [31:0]  m_out;
    logic         m_write_w, m_write_h, m_write_b;
    logic [127:0] s_dat;

    logic [31:0]  m_in;
    logic         m_stall;
    logic [3:0]   s_cs;
    logic [15:0]  s_addr;
    logic [31:0]  s_in;
    logic         s_write_w, s_write_h, s_write_b;
    logic         bus_err;
    logic [15:0]  err_addr;
    logic [7:0]   err_cnt;

    logic [31:0]  b_m_in;
    logic         b_m_stall;
    logic [3:0]   b_s_cs;
    logic [15:0]  b_s_addr;
    logic [31:0]  b_s_in;
    logic         b_s_write_w, b_s_write_h, b_s_write_b;
    logic         b_bus_err;
    logic [15:0]  b_err_addr;
    logic [7:0]   b_err_cnt;

    int total = 0;
    int bad = 0;

    single_bus_interconnect dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_out(m_out),
        .m_write_w(m_write_w), .m_write_h(m_write_h), .m_write_b(m_write_b),
        .m_in(m_in), .m_stall(m_stall), .s_cs(s_cs), .s_addr(s_addr), .s_in(s_in),
        .s_write_w(s_write_w), .s_write_h(s_write_h), .s_write_b(s_write_b),
        .s_dat(s_dat), .bus_err(bus_err), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    // Slaves 0 and 1 share the window 8000/8000.
    single_bus_interconnect #(
        .SLAVE_BASE({16'h1000, 16'h2000, 16'h8000, 16'h8000}),
        .SLAVE_MASK({16'hF000, 16'hE000, 16'h8000, 16'h8000})
    ) dut_ovl (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_out(m_out),
        .m_write_w(m_write_w), .m_write_h(m_write_h), .m_write_b(m_write_b),
        .m_in(b_m_in), .m_stall(b_m_stall), .s_cs(b_s_cs), .s_addr(b_s_addr), .s_in(b_s_in),
        .s_write_w(b_s_write_w), .s_write_h(b_s_write_h), .s_write_b(b_s_write_b),
        .s_dat(s_dat), .bus_err(b_bus_err), .err_addr(b_err_addr), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [2:0] wr);
        m_req  = req;
        m_addr = addr;
        m_out  = wd;
        {m_write_w, m_write_h, m_write_b} = wr;
        #1;
    endtask

    initial begin
        logic [15:0] a;
        rst   = 1'b1;
        s_dat = '0;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        step;
        step;
        $display("txn reset");
        chk("rst_stall", {31'h0, m_stall}, 32'h0);
        chk("rst_cs", {28'h0, s_cs}, 32'h0);
        chk("rst_m_in", m_in, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_err_addr", {16'h0, err_addr}, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        rst = 1'b0;
        step;

        // 1: read slave 0 (L=1)
        $display("txn read 8004 slave0");
        s_dat[31:0] = 32'hDEADBEEF;
        drive(1'b1, 16'h8004, 32'h0, 3'b000);
        chk("t1_cs0", {28'h0, s_cs}, 32'h1);
        chk("t1_stall0", {31'h0, m_stall}, 32'h1);
        step;
        chk("t1_stall1", {31'h0, m_stall}, 32'h0);
        chk("t1_cs1", {28'h0, s_cs}, 32'h1);
        chk("t1_data", m_in, 32'hDEADBEEF);
        step;
        s_dat[31:0] = 32'h0;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        chk("t1_hold", m_in, 32'hDEADBEEF);
        chk("t1_idle_cs", {28'h0, s_cs}, 32'h0);

        // 2: word write slave 1 (L=2)
        $display("txn write 4010 slave1 data 12345678");
        s_dat[63:32] = 32'hCAFE0001;
        drive(1'b1, 16'h4010, 32'h12345678, 3'b100);
        chk("t2_stall0", {31'h0, m_stall}, 32'h1);
        chk("t2_cs0", {28'h0, s_cs}, 32'h2);
        chk("t2_sw0", {31'h0, s_write_w}, 32'h0);
        chk("t2_s_in", s_in, 32'h12345678);
        chk("t2_s_addr", {16'h0, s_addr}, 32'h4010);
        step;
        chk("t2_stall1", {31'h0, m_stall}, 32'h1);
        chk("t2_sw1", {31'h0, s_write_w}, 32'h0);
        chk("t2_cs1", {28'h0, s_cs}, 32'h2);
        step;
        chk("t2_stall2", {31'h0, m_stall}, 32'h0);
        chk("t2_sw2", {31'h0, s_write_w}, 32'h1);
        chk("t2_cs2", {28'h0, s_cs}, 32'h2);
        chk("t2_data", m_in, 32'hCAFE0001);
        step;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        chk("t2_sw3", {31'h0, s_write_w}, 32'h0);
        chk("t2_cs3", {28'h0, s_cs}, 32'h0);
        chk("t2_hold", m_in, 32'hDEADBEEF);

        // 3: unmapped access, then saturate the error counter
        $display("txn read 0100 unmapped");
        drive(1'b1, 16'h0100, 32'h0, 3'b000);
        chk("t3_cs0", {28'h0, s_cs}, 32'h0);
        chk("t3_stall0", {31'h0, m_stall}, 32'h1);
        chk("t3_m_in0", m_in, 32'h0);
        chk("t3_err0", {31'h0, bus_err}, 32'h0);
        step;
        chk("t3_err1", {31'h0, bus_err}, 32'h1);
        chk("t3_stall1", {31'h0, m_stall}, 32'h0);
        chk("t3_cs1", {28'h0, s_cs}, 32'h0);
        step;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        chk("t3_err2", {31'h0, bus_err}, 32'h0);
        chk("t3_err_addr", {16'h0, err_addr}, 32'h0100);
        chk("t3_err_cnt", {24'h0, err_cnt}, 32'h1);
        $display("txn 256 unmapped reads 0200..02FF");
        for (int k = 0; k < 256; k++) begin
            a = 16'h0200 + 16'(k);
            drive(1'b1, a, 32'h0, 3'b000);
            step;
            step;
            if (k == 0)   chk("t3_cnt_2", {24'h0, err_cnt}, 32'h2);
            if (k == 252) chk("t3_cnt_fe", {24'h0, err_cnt}, 32'hFE);
            if (k == 253) chk("t3_cnt_ff", {24'h0, err_cnt}, 32'hFF);
        end
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        chk("t3_cnt_sat", {24'h0, err_cnt}, 32'hFF);
        chk("t3_err_addr_last", {16'h0, err_addr}, 32'h02FF);

        // 4: aborted byte write to slave 3, then a normal read of slave 3 (L=3)
        $display("txn aborted write 1000 slave3");
        s_dat[127:96] = 32'h33330003;
        drive(1'b1, 16'h1000, 32'h55, 3'b001);
        chk("t4_stall0", {31'h0, m_stall}, 32'h1);
        chk("t4_cs0", {28'h0, s_cs}, 32'h8);
        chk("t4_sb0", {31'h0, s_write_b}, 32'h0);
        step;
        chk("t4_stall1", {31'h0, m_stall}, 32'h1);
        chk("t4_sb1", {31'h0, s_write_b}, 32'h0);
        drive(1'b0, 16'h1000, 32'h55, 3'b001);
        chk("t4_abort_stall", {31'h0, m_stall}, 32'h0);
        chk("t4_abort_cs", {28'h0, s_cs}, 32'h0);
        chk("t4_abort_sb", {31'h0, s_write_b}, 32'h0);
        chk("t4_abort_m_in", m_in, 32'hDEADBEEF);
        step;
        $display("txn read 1000 slave3");
        drive(1'b1, 16'h1000, 32'h0, 3'b000);
        chk("t4_r_stall0", {31'h0, m_stall}, 32'h1);
        chk("t4_r_cs0", {28'h0, s_cs}, 32'h8);
        step;
        chk("t4_r_stall1", {31'h0, m_stall}, 32'h1);
        step;
        chk("t4_r_stall2", {31'h0, m_stall}, 32'h1);
        step;
        chk("t4_r_stall3", {31'h0, m_stall}, 32'h0);
        chk("t4_r_data", m_in, 32'h33330003);
        step;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        chk("t4_r_hold", m_in, 32'h33330003);

        // 5: overlapping windows, lowest index wins
        $display("txn read 9000 overlap map");
        s_dat[31:0] = 32'h5A5A0000;
        drive(1'b1, 16'h9000, 32'h0, 3'b000);
        chk("t5_ovl_cs", {28'h0, b_s_cs}, 32'h1);
        chk("t5_ovl_stall0", {31'h0, b_m_stall}, 32'h1);
        chk("t5_def_cs", {28'h0, s_cs}, 32'h1);
        step;
        chk("t5_ovl_stall1", {31'h0, b_m_stall}, 32'h0);
        chk("t5_ovl_data", b_m_in, 32'h5A5A0000);
        step;
        drive(1'b0, 16'h0, 32'h0, 3'b000);

        // 6: asynchronous reset in the middle of a slave 3 wait
        $display("txn read 1000 slave3 with reset mid-wait");
        s_dat[127:96] = 32'h00000077;
        drive(1'b1, 16'h1000, 32'h0, 3'b000);
        step;
        chk("t6_stall_pre", {31'h0, m_stall}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_stall", {31'h0, m_stall}, 32'h0);
        chk("t6_cs", {28'h0, s_cs}, 32'h0);
        chk("t6_m_in", m_in, 32'h0);
        chk("t6_err_cnt", {24'h0, err_cnt}, 32'h0);
        chk("t6_err_addr", {16'h0, err_addr}, 32'h0);
        chk("t6_bus_err", {31'h0, bus_err}, 32'h0);
        step;
        drive(1'b0, 16'h0, 32'h0, 3'b000);
        rst = 1'b0;
        step;
        chk("t6_post_stall", {31'h0, m_stall}, 32'h0);
        chk("t6_post_m_in", m_in, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/single_bus_interconnect.md
Name: single_bus_interconnect

Overview:
- Parametrised address decoder, wait-state generator and read-data multiplexer for the single-bus RISC-V Lite SoC.
- Connects one master (core pgm_* bus) to NR_OF_SLAVES memory/IO slaves.
- Replaces hardwired chip-select decode and the fixed 1'b0 core_stall with per-slave address windows, per-slave wait states driving core_stall, and unmapped-access error capture.

Parameters:
ADDR_BUS_WIDTH, 16, master/slave address width.
NR_OF_SLAVES, 4, number of slaves, 1..8.
SLAVE_BASE, {16'h1000,16'h2000,16'h4000,16'h8000}, packed base addresses, slave 0 in LSBs.
SLAVE_MASK, {16'hF000,16'hE000,16'hC000,16'h8000}, packed decode masks; hit when (addr & MASK) == BASE.
SLAVE_WAIT, 16'h2010, packed 4-bit wait count per slave, slave 0 in LSBs (defaults: 0,1,0,2).
SYNCHRONOUS_OUTPUT, "TRUE", adds 1 cycle of latency to every slave (registered slave outputs).

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous, active-high reset.
m_req  input  1  master access valid this cycle.
m_addr  input  ADDR_BUS_WIDTH  master address.
m_out  input  32  master write data.
m_write_w, m_write_h, m_write_b  input  1 each  master write strobes.
m_in  output  32  read data to master.
m_stall  output  1  to core_stall; master holds all inputs stable while high.
s_cs  output  NR_OF_SLAVES  one-hot slave selects.
s_addr  output  ADDR_BUS_WIDTH  address to slaves.
s_in  output  32  write data to slaves.
s_write_w, s_write_h, s_write_b  output  1 each  gated write strobes.
s_dat  input  32*NR_OF_SLAVES  packed slave read data, slave 0 in LSBs.
bus_err  output  1  one-cycle pulse on an unmapped access.
err_addr  output  ADDR_BUS_WIDTH  address of the last unmapped access.
err_cnt  output  8  saturating count of unmapped accesses.

Behaviour:
- Reset (async, immediate): FSM=IDLE, m_stall=0, s_cs=0, all s_write_*=0, m_in=0, bus_err=0, err_addr=0, err_cnt=0.
- Decode: the lowest-index hit wins when windows overlap. Latency L = SLAVE_WAIT[i] + (SYNCHRONOUS_OUTPUT=="TRUE").
- s_addr and s_in are combinational passthroughs of m_addr and m_out.
- FSM states: IDLE, WAIT, ERR.
- IDLE, m_req=1, hit slave i, L=0:
  - s_cs[i]=1 combinationally.
  - Access completes in the same cycle: m_in = s_dat[i] combinationally, m_stall=0, s_write_* = m_write_*.
  - FSM stays in IDLE.
- IDLE, m_req=1, hit slave i, L>0:
  - Same cycle: s_cs[i]=1, m_stall=1 (combinational), s_write_*=0.
  - Latch index i and load counter=L-1. Go to WAIT.
- WAIT:
  - s_cs[latched i]=1.
  - While counter≠0: m_stall=1, decrement.
  - Counter==0 is the completion cycle: m_stall=0, m_in=s_dat[i], s_write_* = m_write_*. Return to IDLE.
  - Write strobes reach the slave only in the completion cycle, so each write is issued exactly once.
- m_req dropped while in WAIT: abort, no write issued, m_stall=0 that cycle, s_cs=0, return to IDLE.
- Unmapped access (IDLE, m_req=1, no hit):
  - s_cs=0, s_write_*=0, m_in=32'h0, m_stall=1 for one cycle. Go to ERR.
  - ERR lasts one cycle: bus_err=1, m_stall=0, err_addr <= latched address, err_cnt <= err_cnt+1 (saturates at 8'hFF). Return to IDLE.
  - Writes and reads are treated identically.
- m_in holding: registered hold of the last completed read value when no access is completing; m_in=0 only after reset.
- Back-to-back accesses: IDLE accepts a new request in the cycle after completion. An L=0 slave can complete every cycle.
- m_addr changing during WAIT is a protocol violation; decode uses the latched index and the behaviour is otherwise undefined.

Test Plan:
1. After reset, read 16'h8004 (slave 0, L=1 with sync), s_dat[0]=32'hDEADBEEF -> m_stall=1 for 1 cycle; next cycle m_in=32'hDEADBEEF, s_cs=4'b0001.
2. Word write 32'h12345678 to 16'h4010 (slave 1, L=2) -> m_stall high for 2 cycles; s_write_w=1 for exactly 1 cycle (completion), s_cs=4'b0010.
3. Read 16'h0100 (unmapped) -> m_stall 1 cycle, then bus_err pulse, err_addr=16'h0100, err_cnt=1, m_in=0; 256 further unmapped accesses -> err_cnt=8'hFF.
4. Read 16'h1000 (slave 3, L=3), drop m_req after the first stall cycle -> m_stall=0 that cycle, no s_write_*, FSM back in IDLE; next request is serviced normally.
5. Overlap: SLAVE_BASE slaves 0 and 1 both 16'h8000 with mask 16'h8000 -> access 16'h9000 selects slave 0 only (s_cs=4'b0001).
6. Assert rst mid-WAIT on a slave 3 access -> m_stall, s_cs and m_in go to 0 immediately; err_cnt=0.
